// File: rtl/float_accum.sv
// Burst accumulator that sums 8-bit {exp,mant} operands through an external
// combinational float adder and returns the sum, operand count and saturation flag.
module float_accum #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [7:0]       add_result,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       acc;
    logic [7:0]       opnd;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic             last;
    logic             xfer;

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                state_nxt = last ? DONE : WAIT;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A transfer out of IDLE opens a new burst, so the running sum starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opnd  <= '0;
            count <= '0;
            sat   <= 1'b0;
            last  <= 1'b0;
        end else begin
            if (xfer) begin
                opnd <= in_data;
                last <= in_last;
                if (state == IDLE) begin
                    acc   <= '0;
                    count <= '0;
                    sat   <= 1'b0;
                end
            end
            if (state == ADD) begin
                acc <= add_result;
                if (count != '1) begin
                    count <= count + 1'b1;
                end
                sat <= sat || (add_result == 8'hFF);
            end
        end
    end

    assign add_a     = acc;
    assign add_b     = opnd;
    assign out_data  = acc;
    assign out_count = count;
    assign out_sat   = sat;

endmodule

// File: tb/tb_float_accum.sv
// Randomised burst bench for float_accum with a behavioural adder and
// a fold-over-burst reference for sum, count and saturation.
module tb_float_accum;

    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_result;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] out_count;
    logic       out_sat;
    logic       out_ready;

    int nvec = 0;
    int nerr = 0;
    int ops[$];

    float_accum #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_result(add_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Value = mant * 2^exp; align to the larger exponent, one renormalising shift, saturate.
    function automatic logic [7:0] fadd(input logic [7:0] a, input logic [7:0] b);
        int ea = int'(a[7:5]);
        int eb = int'(b[7:5]);
        int e  = (ea > eb) ? ea : eb;
        int s  = (int'(a[4:0]) >> (e - ea)) + (int'(b[4:0]) >> (e - eb));
        logic [7:0] r;
        if (s > 31) begin
            s = s >> 1;
            e = e + 1;
        end
        if (e > 7) return 8'hFF;
        r = {e[2:0], s[4:0]};
        return r;
    endfunction

    always_comb add_result = fadd(add_a, add_b);

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_count"}, int'(out_count), 0);
        chk({tag, "_out_sat"}, int'(out_sat), 0);
        chk({tag, "_add_a"}, int'(add_a), 0);
        chk({tag, "_add_b"}, int'(add_b), 0);
    endtask

    // Sends the operands in ops[], then checks latency, result and backpressure.
    task automatic send_burst(input int hold, input bit gaps);
        logic [7:0] exp_sum = 8'h00;
        bit         exp_sat = 1'b0;
        int         exp_cnt;
        bit         ok;
        foreach (ops[i]) begin
            exp_sum = fadd(exp_sum, ops[i][7:0]);
            if (exp_sum == 8'hFF) exp_sat = 1'b1;
        end
        exp_cnt = (ops.size() > CMAX) ? CMAX : ops.size();
        foreach (ops[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = ops[i][7:0];
            in_last  = (i == ops.size() - 1);
            ok = 1'b0;
            for (int t = 0; t < 8 && !ok; t++) begin
                ok = in_ready;
                @(posedge clk);
                @(negedge clk);
            end
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            if (!ok) begin
                chk("accept_timeout", 0, 1);
                return;
            end
        end
        // First negedge after the last transfer is the ADD cycle.
        chk("lat_add", int'(out_valid), 0);
        @(negedge clk);
        chk("lat_done", int'(out_valid), 1);
        chk("sum", int'(out_data), int'(exp_sum));
        chk("count", int'(out_count), exp_cnt);
        chk("sat", int'(out_sat), int'(exp_sat));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_ready", int'(in_ready), 0);
            chk("hold_sum", int'(out_data), int'(exp_sum));
            chk("hold_count", int'(out_count), exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_ready", int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=0 exp=1");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        ops = '{8'h25};             send_burst(0, 1'b0);
        ops = '{8'h21, 8'h21};      send_burst(0, 1'b0);
        ops = '{8'hFF, 8'hFF};      send_burst(0, 1'b0);
        ops = '{8'h13, 8'h47};      send_burst(5, 1'b0);
        ops.delete();
        for (int i = 0; i < 17; i++) ops.push_back(0);
        send_burst(1, 1'b0);

        // Reset while the block is in ADD aborts the burst.
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_add_b", int'(add_b), 8'h33);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ops = '{8'h25};             send_burst(0, 1'b0);

        for (int b = 0; b < 30; b++) begin
            int len = $urandom_range(1, 20);
            ops.delete();
            for (int i = 0; i < len; i++) begin
                ops.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(224, 255))
                                                          : int'($urandom_range(0, 255)));
            end
            send_burst($urandom_range(0, 4), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
